gate_sweeper: RTL
=================

GATE_SWEEPER -- requirements
Module: gate_sweeper

Interface
REQ-001 Parameter N_IN, default 2: gate input count (2..8).
REQ-002 Parameter TICK_DIV, default 4: clocks per sweep step (>=1).
REQ-003 Port clk  input  1  single system clock, all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port mode  input  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
REQ-006 Port sw  input  N_IN  manual gate inputs (switches), synchronous to clk.
REQ-007 Port sweep_start  input  1  level sampled each clock; starts truth-table sweep.
REQ-008 Port vec  output  N_IN  registered vector currently applied to the gate.
REQ-009 Port y  output  1  registered gate result.
REQ-010 Port busy  output  1  high while a sweep runs.
REQ-011 Port step  output  1  one-cycle pulse each time vec advances during a sweep.
REQ-012 Port done  output  1  one-cycle pulse on sweep completion.

Function
REQ-013 N-input reduction over all bits of vec; NAND/NOR/XNOR are the inverted AND/OR/XOR reductions.
REQ-014 y SHALL equal f(mode, vec) registered: y lags vec and mode by exactly one clock.
REQ-015 Reserved mode (6, 7) SHALL drive y to 0.
REQ-016 FSM states IDLE, RUN, FIN.
REQ-017 IDLE: vec <= sw each clock; busy=0; IDLE->RUN when sweep_start=1.
REQ-018 On the IDLE->RUN transition, vec <= 0, the tick counter clears, and busy=1 from the next cycle.
REQ-019 RUN: tick counter counts 0..TICK_DIV-1; on terminal count vec <= vec+1, step pulses high for that cycle, and the counter wraps to 0.
REQ-020 RUN: when the terminal count is reached with vec = 2**N_IN-1, vec SHALL hold, step SHALL NOT pulse, and the FSM SHALL go to FIN.
REQ-021 FIN: done=1 for exactly one cycle, busy=0, and the FSM returns to IDLE; vec is reloaded from sw on the following cycle.
REQ-022 sweep_start while in RUN or FIN SHALL be ignored (no restart).
REQ-023 sweep_start held high through FIN SHALL start a new sweep from IDLE on the next cycle.
REQ-024 A mode change during RUN SHALL affect y one clock later and SHALL NOT disturb vec or timing.
REQ-025 Each vector SHALL be presented for exactly TICK_DIV cycles; the sweep length from the first vec=0 cycle to done is 2**N_IN*TICK_DIV cycles.

Reset
REQ-026 rst_n=0 SHALL immediately force FSM=IDLE, vec=0, y=0, busy=0, step=0, done=0, tick counter=0, including mid-sweep.
REQ-027 After rst_n release, the first rising edge SHALL resume IDLE behaviour; there SHALL be no spurious done or step pulse.

Configuration
REQ-028 Macro GATE_SWEEP_EN: when defined, sweep logic (REQ-016..025) is compiled in.
REQ-029 GATE_SWEEP_EN undefined: sweep_start is ignored; busy, step and done are tied to 0; vec <= sw every clock; y behaves per REQ-014; the port list is unchanged.

Structure
REQ-030 Package gate_pkg SHALL hold the mode encoding constants, the FSM state typedef and the reserved-mode output value.
REQ-031 Sub-module gate_eval SHALL be the combinational N_IN-input reduction (mode, vec -> result); gate_sweeper registers its output.

Verification
REQ-032 N_IN=2, mode=0, sw stepped 00,01,10,11 (10 clocks each) -> vec follows sw after 1 clock; y=0,0,0,1 after a further clock.
REQ-033 N_IN=2, TICK_DIV=4, mode=2, pulse sweep_start -> vec 0,1,2,3 each held 4 clocks; y=0,1,1,0 lagging 1 clock; 3 step pulses; done one cycle after the last vec period; busy high 16 cycles.
REQ-034 Sweep running at vec=2, rst_n low for 1 cycle -> all outputs 0 asynchronously; after release vec follows sw; no done pulse.
REQ-035 mode=6 with sw=11 -> y=0; switch to mode=3 -> y=0 one clock later; sw=01 -> y=1.
REQ-036 sweep_start held high continuously, N_IN=3, TICK_DIV=1 -> back-to-back sweeps of 8 cycles, each separated by one FIN and one IDLE cycle; done pulses every 10 cycles; sweep_start is ignored mid-run.
REQ-037 Build without GATE_SWEEP_EN, pulse sweep_start -> busy, step and done stay 0; vec tracks sw.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for gate_sweeper: mode encodings, sweep FSM states and the reserved-mode output.
package gate_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic RESERVED_Y = 1'b0;

    // A divide-by-one counter still needs one bit so the register is never zero-width.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/gate_eval.sv
// Combinational N_IN-input gate: reduces every bit of vec according to mode.
module gate_eval
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [N_IN-1:0]   vec,
    output logic              result
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        result = RESERVED_Y;
        case (mode_e'(mode))
            MODE_AND:  result = &vec;
            MODE_OR:   result = |vec;
            MODE_XOR:  result = ^vec;
            MODE_NAND: result = ~(&vec);
            MODE_NOR:  result = ~(|vec);
            MODE_XNOR: result = ~(^vec);
            default:   result = RESERVED_Y;
        endcase
    end

endmodule

// File: rtl/gate_sweeper.sv
// Registered N_IN-input logic gate with an optional truth-table sweeper.
// Define GATE_SWEEP_EN to build the sweep FSM; otherwise vec simply follows sw.
module gate_sweeper
    import gate_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic [N_IN-1:0]   sw,
    input  logic              sweep_start,
    output logic [N_IN-1:0]   vec,
    output logic              y,
    output logic              busy,
    output logic              step,
    output logic              done
);

    logic [N_IN-1:0] vec_q, vec_d;
    logic            y_q, y_d;

    gate_eval #(.N_IN(N_IN)) u_eval (
        .mode   (mode),
        .vec    (vec_q),
        .result (y_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            vec_q <= '0;
            y_q   <= 1'b0;
        end else begin
            vec_q <= vec_d;
            y_q   <= y_d;
        end
    end

    assign vec = vec_q;
    assign y   = y_q;

`ifdef GATE_SWEEP_EN

    localparam int              CNT_W     = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [N_IN-1:0]  VEC_LAST  = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             tick_end;

    assign tick_end = (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE: begin
                vec_d  = sw;
                tick_d = '0;
                if (sweep_start) begin
                    state_d = ST_RUN;
                    vec_d   = '0;
                end
            end
            ST_RUN: begin
                if (tick_end) begin
                    tick_d = '0;
                    // The last vector keeps its value through FIN; IDLE reloads sw afterwards.
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Status outputs decode registered state only, so reset clears them at once.
    assign busy = (state_q == ST_RUN);
    assign step = (state_q == ST_RUN) && tick_end && (vec_q != VEC_LAST);
    assign done = (state_q == ST_FIN);

`else

    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start;
    assign vec_d = sw;
    assign busy  = 1'b0;
    assign step  = 1'b0;
    assign done  = 1'b0;

`endif

endmodule
